// File: rtl/apb_pwm_driver.sv
// -----------------------------------------------------------------------------
// apb_pwm_driver
// APB3 slave driving two independent PWM / pulse-burst channels. Each channel
// runs a counter over a shared PERIOD with its own DUTY and optional BURST
// length; a finite burst sets a sticky DONE flag that is turned into a level
// interrupt when the matching interrupt enable is set.
//
// Ports
//   PCLK     in   clock, all logic on the rising edge
//   PRESET   in   synchronous active-high reset
//   PSEL     in   peripheral select
//   PENABLE  in   APB access phase
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address, only [4:2] decoded
//   PWDATA   in   write data
//   PRDATA   out  registered read data
//   PREADY   out  tied high (zero wait states)
//   PSLVERR  out  tied low
//   OUT      out  registered PWM outputs, bit n = channel n
//   INT0     out  channel 0 done interrupt (level)
//   INT1     out  channel 1 done interrupt (level)
//
// Register map (PADDR[4:2]):
//   0 CTRL   {IE1,IE0,EN1,EN0}      1 PERIOD     2 DUTY0    3 DUTY1
//   4 BURST0                        5 BURST1     6 STATUS {DONE1,DONE0,BUSY1,BUSY0}
//   7 reserved (reads 0)
// -----------------------------------------------------------------------------
module apb_pwm_driver #(
    parameter int CW = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [1:0]  OUT,
    output logic        INT0,
    output logic        INT1
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_PERIOD = 3'd1;
    localparam logic [2:0] ADDR_DUTY0  = 3'd2;
    localparam logic [2:0] ADDR_DUTY1  = 3'd3;
    localparam logic [2:0] ADDR_BURST0 = 3'd4;
    localparam logic [2:0] ADDR_BURST1 = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    // Bus decode
    logic        wr_s;
    logic        rd_setup_s;
    logic [2:0]  addr_s;
    logic        ctrl_wr_s;
    logic [1:0]  w1c_s;
    logic        unused_s;

    // Configuration and status registers
    logic [1:0]    ie_r;
    logic [CW-1:0] period_r;
    logic [CW-1:0] duty_r  [2];
    logic [CW-1:0] burst_r [2];
    logic [1:0]    done_r;
    logic [1:0]    done_nxt_s;
    logic [1:0]    int_r;
    logic [31:0]   prdata_r;
    logic [31:0]   rdata_s;

    // Channel state and datapath
    ch_state_t     state_r     [2];
    ch_state_t     state_nxt_s [2];
    logic [CW-1:0] cnt_r       [2];
    logic [CW-1:0] cnt_nxt_s   [2];
    logic [CW-1:0] rem_r       [2];
    logic [CW-1:0] rem_nxt_s   [2];
    logic [CW-1:0] p_sh_r      [2];
    logic [CW-1:0] p_sh_nxt_s  [2];
    logic [CW-1:0] d_sh_r      [2];
    logic [CW-1:0] d_sh_nxt_s  [2];
    logic [1:0]    out_r;
    logic [1:0]    out_nxt_s;
    logic [1:0]    busy_s;
    logic [1:0]    start_s;
    logic [1:0]    abort_s;
    logic [1:0]    wrap_s;
    logic [1:0]    finish_s;

    assign wr_s       = PSEL & PENABLE & PWRITE;
    assign rd_setup_s = PSEL & ~PENABLE & ~PWRITE;
    assign addr_s     = PADDR[4:2];
    assign ctrl_wr_s  = wr_s & (addr_s == ADDR_CTRL);
    assign w1c_s      = (wr_s & (addr_s == ADDR_STATUS)) ? PWDATA[3:2] : 2'b00;
    assign unused_s   = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:CW]};

    // Per-channel events: start, abort, period wrap and last wrap of a burst
    always_comb begin
        start_s  = 2'b00;
        abort_s  = 2'b00;
        wrap_s   = 2'b00;
        finish_s = 2'b00;
        busy_s   = 2'b00;
        for (int n = 0; n < 2; n++) begin
            busy_s[n]   = (state_r[n] == ST_RUN);
            // A CTRL write only starts an idle channel; setting EN again while
            // running is deliberately a no-op (no restart).
            start_s[n]  = ctrl_wr_s & PWDATA[n] & (state_r[n] == ST_IDLE);
            abort_s[n]  = ctrl_wr_s & ~PWDATA[n] & (state_r[n] == ST_RUN);
            wrap_s[n]   = (state_r[n] == ST_RUN) & (cnt_r[n] == p_sh_r[n]);
            // rem == 0 marks a continuous channel, so it never finishes.
            finish_s[n] = wrap_s[n] & (rem_r[n] == CW'(1));
        end
    end

    // Channel FSM next-state logic
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_nxt_s[n] = state_r[n];
            case (state_r[n])
                ST_IDLE: begin
                    if (start_s[n]) begin
                        state_nxt_s[n] = ST_RUN;
                    end else begin
                        state_nxt_s[n] = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort_s[n] | finish_s[n]) begin
                        state_nxt_s[n] = ST_IDLE;
                    end else begin
                        state_nxt_s[n] = ST_RUN;
                    end
                end
                default: state_nxt_s[n] = ST_IDLE;
            endcase
        end
    end

    // Channel FSM outputs: counter, burst remainder, shadow registers, PWM level
    always_comb begin
        out_nxt_s = 2'b00;
        for (int n = 0; n < 2; n++) begin
            cnt_nxt_s[n]  = cnt_r[n];
            rem_nxt_s[n]  = rem_r[n];
            p_sh_nxt_s[n] = p_sh_r[n];
            d_sh_nxt_s[n] = d_sh_r[n];
            case (state_r[n])
                ST_IDLE: begin
                    if (start_s[n]) begin
                        // Output is valid on the start edge itself (cnt = 0).
                        cnt_nxt_s[n]  = CW'(0);
                        rem_nxt_s[n]  = burst_r[n];
                        p_sh_nxt_s[n] = period_r;
                        d_sh_nxt_s[n] = duty_r[n];
                        out_nxt_s[n]  = (duty_r[n] != CW'(0));
                    end else begin
                        out_nxt_s[n]  = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort_s[n]) begin
                        out_nxt_s[n] = 1'b0;
                    end else if (finish_s[n]) begin
                        cnt_nxt_s[n] = CW'(0);
                        rem_nxt_s[n] = CW'(0);
                        out_nxt_s[n] = 1'b0;
                    end else if (wrap_s[n]) begin
                        // Period boundary: pick up any PERIOD/DUTY written
                        // during the period that just ended.
                        cnt_nxt_s[n]  = CW'(0);
                        p_sh_nxt_s[n] = period_r;
                        d_sh_nxt_s[n] = duty_r[n];
                        out_nxt_s[n]  = (duty_r[n] != CW'(0));
                        if (rem_r[n] != CW'(0)) begin
                            rem_nxt_s[n] = rem_r[n] - CW'(1);
                        end else begin
                            rem_nxt_s[n] = rem_r[n];
                        end
                    end else begin
                        cnt_nxt_s[n] = cnt_r[n] + CW'(1);
                        out_nxt_s[n] = ((cnt_r[n] + CW'(1)) < d_sh_r[n]);
                    end
                end
                default: begin
                    out_nxt_s[n] = 1'b0;
                end
            endcase
        end
    end

    // DONE flags: set by a finishing burst, cleared by W1C; a set wins a collision
    always_comb begin
        done_nxt_s = (done_r & ~w1c_s) | (finish_s & ~abort_s);
    end

    // Read data mux for the addressed register
    always_comb begin
        case (addr_s)
            ADDR_CTRL:   rdata_s = {28'd0, ie_r, busy_s};
            ADDR_PERIOD: rdata_s = 32'(period_r);
            ADDR_DUTY0:  rdata_s = 32'(duty_r[0]);
            ADDR_DUTY1:  rdata_s = 32'(duty_r[1]);
            ADDR_BURST0: rdata_s = 32'(burst_r[0]);
            ADDR_BURST1: rdata_s = 32'(burst_r[1]);
            ADDR_STATUS: rdata_s = {28'd0, done_r, busy_s};
            default:     rdata_s = 32'd0;
        endcase
    end

    // Channel FSM state register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r[0] <= ST_IDLE;
            state_r[1] <= ST_IDLE;
        end else begin
            state_r[0] <= state_nxt_s[0];
            state_r[1] <= state_nxt_s[1];
        end
    end

    // Channel datapath registers and PWM outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int n = 0; n < 2; n++) begin
                cnt_r[n]  <= CW'(0);
                rem_r[n]  <= CW'(0);
                p_sh_r[n] <= CW'(0);
                d_sh_r[n] <= CW'(0);
            end
            out_r <= 2'b00;
        end else begin
            for (int n = 0; n < 2; n++) begin
                cnt_r[n]  <= cnt_nxt_s[n];
                rem_r[n]  <= rem_nxt_s[n];
                p_sh_r[n] <= p_sh_nxt_s[n];
                d_sh_r[n] <= d_sh_nxt_s[n];
            end
            out_r <= out_nxt_s;
        end
    end

    // Writable configuration registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ie_r       <= 2'b00;
            period_r   <= CW'(0);
            duty_r[0]  <= CW'(0);
            duty_r[1]  <= CW'(0);
            burst_r[0] <= CW'(0);
            burst_r[1] <= CW'(0);
        end else if (wr_s) begin
            case (addr_s)
                ADDR_CTRL:   ie_r       <= PWDATA[3:2];
                ADDR_PERIOD: period_r   <= PWDATA[CW-1:0];
                ADDR_DUTY0:  duty_r[0]  <= PWDATA[CW-1:0];
                ADDR_DUTY1:  duty_r[1]  <= PWDATA[CW-1:0];
                ADDR_BURST0: burst_r[0] <= PWDATA[CW-1:0];
                ADDR_BURST1: burst_r[1] <= PWDATA[CW-1:0];
                default: begin
                end
            endcase
        end else begin
            ie_r <= ie_r;
        end
    end

    // DONE flags and level interrupts (interrupt lags DONE by one edge)
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            done_r <= 2'b00;
            int_r  <= 2'b00;
        end else begin
            done_r <= done_nxt_s;
            int_r  <= done_r & ie_r;
        end
    end

    // Read data captured in the setup phase and held through the access phase
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prdata_r <= 32'd0;
        end else if (rd_setup_s) begin
            prdata_r <= rdata_s;
        end else begin
            prdata_r <= prdata_r;
        end
    end

    assign PRDATA  = prdata_r;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign OUT     = out_r;
    assign INT0    = int_r[0];
    assign INT1    = int_r[1];

endmodule

// File: tb/tb_apb_pwm_driver.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for apb_pwm_driver. One task per scenario, each
// with hand-computed expected values, run in sequence from a single initial.
// -----------------------------------------------------------------------------
module tb_apb_pwm_driver;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [1:0]  OUT;
    logic        INT0;
    logic        INT1;

    int checks;
    int errors;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_PERIOD = 32'h04;
    localparam logic [31:0] A_DUTY0  = 32'h08;
    localparam logic [31:0] A_DUTY1  = 32'h0C;
    localparam logic [31:0] A_BURST0 = 32'h10;
    localparam logic [31:0] A_BURST1 = 32'h14;
    localparam logic [31:0] A_STATUS = 32'h18;

    apb_pwm_driver #(.CW(16)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .OUT     (OUT),
        .INT0    (INT0),
        .INT1    (INT1)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Write: returns 1 time unit after the commit edge.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Read: data sampled during the access phase.
    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        @(negedge PCLK);
        PENABLE = 1'b1;
        data = PRDATA;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        @(posedge PCLK);
        @(posedge PCLK);
        #1;
        checks++;
        if ({OUT, INT0, INT1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {OUT, INT0, INT1});
        end
        checks++;
        if (PRDATA !== 32'd0) begin
            errors++;
            $display("FAIL reset_prdata: got %0h expected 0", PRDATA);
        end
        checks++;
        if ({PREADY, PSLVERR} !== 2'b10) begin
            errors++;
            $display("FAIL ready_slverr: got %b expected 10", {PREADY, PSLVERR});
        end
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic test_burst();
        logic [7:0]  pat;
        logic [31:0] rd;
        pat = 8'b0001_0001;   // bit i = expected OUT[0] i edges after start
        apb_write(A_PERIOD, 32'd3);
        apb_write(A_DUTY0, 32'd1);
        apb_write(A_BURST0, 32'd2);
        apb_write(A_CTRL, 32'h5);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge PCLK);
                #1;
            end
            checks++;
            if (OUT[0] !== pat[i]) begin
                errors++;
                $display("FAIL burst_out[%0d]: got %b expected %b", i, OUT[0], pat[i]);
            end
        end
        @(posedge PCLK);
        #1;
        checks++;
        if ({OUT[0], INT0} !== 2'b00) begin
            errors++;
            $display("FAIL burst_done_edge: got out/int %b expected 00", {OUT[0], INT0});
        end
        @(posedge PCLK);
        #1;
        checks++;
        if (INT0 !== 1'b1) begin
            errors++;
            $display("FAIL burst_int0: got %b expected 1", INT0);
        end
        apb_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL burst_status: got %0h expected 4", rd);
        end
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL burst_ctrl: got %0h expected 4", rd);
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        apb_write(A_STATUS, 32'h4);
        checks++;
        if (INT0 !== 1'b1) begin
            errors++;
            $display("FAIL w1c_int_lag: got %b expected 1", INT0);
        end
        @(posedge PCLK);
        #1;
        checks++;
        if (INT0 !== 1'b0) begin
            errors++;
            $display("FAIL w1c_int_fall: got %b expected 0", INT0);
        end
        apb_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL w1c_status: got %0h expected 0", rd);
        end
        // One-period burst: DONE0 sets 4 edges after start; W1C commits there too.
        apb_write(A_BURST0, 32'd1);
        apb_write(A_CTRL, 32'h5);
        @(posedge PCLK);
        #1;
        @(posedge PCLK);
        #1;
        apb_write(A_STATUS, 32'h4);
        apb_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL collision_status: got %0h expected 4", rd);
        end
    endtask

    task automatic test_shadowing();
        logic [19:0] h;
        apb_write(A_PERIOD, 32'd9);
        apb_write(A_DUTY1, 32'd5);
        apb_write(A_BURST1, 32'd0);
        apb_write(A_CTRL, 32'hA);
        h = 20'd0;
        h[0] = OUT[1];
        fork
            apb_write(A_DUTY1, 32'd2);
            begin
                for (int i = 1; i < 20; i++) begin
                    @(posedge PCLK);
                    #1;
                    h[i] = OUT[1];
                end
            end
        join
        checks++;
        if (h[9:0] !== 10'h01F) begin
            errors++;
            $display("FAIL shadow_period1: got %b expected 0000011111", h[9:0]);
        end
        checks++;
        if (h[19:10] !== 10'h003) begin
            errors++;
            $display("FAIL shadow_period2: got %b expected 0000000011", h[19:10]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        // Commits on the second cycle of a period where OUT[1] would be high.
        apb_write(A_CTRL, 32'h8);
        checks++;
        if (OUT[1] !== 1'b0) begin
            errors++;
            $display("FAIL abort_out: got %b expected 0", OUT[1]);
        end
        @(posedge PCLK);
        #1;
        checks++;
        if ({OUT[1], INT1} !== 2'b00) begin
            errors++;
            $display("FAIL abort_hold: got out/int %b expected 00", {OUT[1], INT1});
        end
        apb_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL abort_status: got %0h expected 4", rd);
        end
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h8) begin
            errors++;
            $display("FAIL abort_ctrl: got %0h expected 8", rd);
        end
    endtask

    task automatic run_extreme(input logic [31:0] duty, input logic [3:0] exp_pat);
        logic [3:0] v;
        apb_write(A_STATUS, 32'h4);
        apb_write(A_PERIOD, 32'd3);
        apb_write(A_DUTY0, duty);
        apb_write(A_BURST0, 32'd1);
        apb_write(A_CTRL, 32'hD);
        v = 4'd0;
        v[0] = OUT[0];
        for (int i = 1; i < 4; i++) begin
            @(posedge PCLK);
            #1;
            v[i] = OUT[0];
        end
        checks++;
        if (v !== exp_pat) begin
            errors++;
            $display("FAIL extreme_out duty=%0d: got %b expected %b", duty, v, exp_pat);
        end
        @(posedge PCLK);
        #1;
        checks++;
        if ({OUT[0], INT0} !== 2'b00) begin
            errors++;
            $display("FAIL extreme_done_edge duty=%0d: got %b expected 00", duty, {OUT[0], INT0});
        end
        @(posedge PCLK);
        #1;
        checks++;
        if (INT0 !== 1'b1) begin
            errors++;
            $display("FAIL extreme_int duty=%0d: got %b expected 1", duty, INT0);
        end
    endtask

    task automatic test_extremes();
        run_extreme(32'd0, 4'b0000);
        run_extreme(32'd4, 4'b1111);
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] rd;
        apb_write(A_BURST0, 32'd0);
        apb_write(A_CTRL, 32'hD);
        apb_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h5) begin
            errors++;
            $display("FAIL pre_reset_status: got %0h expected 5", rd);
        end
        checks++;
        if ({OUT[0], INT0} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_out: got %b expected 11", {OUT[0], INT0});
        end
        @(negedge PCLK);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        checks++;
        if ({OUT, INT0, INT1} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 0000", {OUT, INT0, INT1});
        end
        checks++;
        if (PRDATA !== 32'd0) begin
            errors++;
            $display("FAIL midreset_prdata: got %0h expected 0", PRDATA);
        end
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        for (int a = 0; a < 8; a++) begin
            apb_read(32'(a * 4), rd);
            checks++;
            if (rd !== 32'd0) begin
                errors++;
                $display("FAIL midreset_reg%0d: got %0h expected 0", a, rd);
            end
        end
        checks++;
        if (OUT !== 2'b00) begin
            errors++;
            $display("FAIL postreset_out: got %b expected 00", OUT);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'd0;
        PWDATA  = 32'd0;
        test_reset();
        test_burst();
        test_w1c_collision();
        test_shadowing();
        test_abort();
        test_extremes();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_pwm_driver.md
# apb_pwm_driver

APB3 slave that turns processor register writes into two PWM/pulse-burst output channels (haptic motors, LEDs) and raises a per-channel fabric interrupt when a finite burst completes. It is the output-direction counterpart of the switch-input interrupt peripheral: the processor drives pins through this block, and each completion is reported back on INT0/INT1 to the fabric interrupt lines. It sits on the same APB3 bus segment as the other fabric peripherals.

## Interface
- CW, 16, width of the period, duty and burst counters/registers
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- PSEL  in  1  peripheral select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  byte address; only PADDR[4:2] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data, registered
- PREADY  out  1  tied 1 (zero wait states)
- PSLVERR  out  1  tied 0
- OUT  out  2  PWM outputs, registered
- INT0  out  1  channel 0 done interrupt, level
- INT1  out  1  channel 1 done interrupt, level

## Operation
- Register map, by PADDR[4:2]: 0 CTRL {IE1,IE0,EN1,EN0} in bits [3:0]; 1 PERIOD (CW bits, shared); 2 DUTY0; 3 DUTY1; 4 BURST0; 5 BURST1; 6 STATUS {DONE1,DONE0,BUSY1,BUSY0} in bits [3:0]; 7 reads 0, writes are ignored.
- Unused bits read 0. A write commits when PSEL & PENABLE & PWRITE.
- STATUS is read-only except DONE bits, which are write-1-to-clear. BUSYn equals ENn.
- Per-channel FSM, IDLE/RUN:
  - IDLE -> RUN on a write that sets ENn while ENn is 0. The same edge loads cnt=0, rem=BURSTn, P_sh=PERIOD and D_sh=DUTYn.
  - RUN: cnt counts 0..P_sh (period = P_sh+1 cycles). OUTn = (cnt < D_sh). D_sh=0 holds the output low; D_sh>P_sh holds it high.
  - At wrap (cnt==P_sh), cnt becomes 0 and P_sh/D_sh reload from the registers. PERIOD and DUTY writes during RUN therefore take effect only at the next period boundary.
  - At wrap with BURSTn loaded nonzero: if rem==1, go to IDLE, clear ENn, set DONEn and drive OUTn 0; otherwise rem decrements.
  - BURSTn=0 means continuous operation, with no DONE.
  - Writing ENn=0 while in RUN aborts: IDLE on that edge, OUTn 0 on that edge, DONE unchanged.
  - Writing ENn=1 while already in RUN has no effect, with no restart.
- INTn = DONEn & IEn, registered. It stays high until DONEn is cleared or IEn is cleared.
- Simultaneous DONE set and W1C on the same edge: set wins.
- Read: PRDATA is loaded on the setup edge (PSEL & ~PENABLE & ~PWRITE) with the addressed register. It holds otherwise.

## Timing
- Reset (PRESET=1 at an edge): all registers, counters, FSMs to IDLE. OUT=0, INT0=INT1=0, PRDATA=0. Reset overrides any bus access in the same cycle.
- Reset mid-burst: OUT low on that edge, and no DONE is reported.
- Start latency: OUTn is valid on the edge that commits the EN write, i.e. in the first cycle after the access phase. It is high for exactly D_sh cycles per period.
- Finite burst length: the last wrap edge is BURSTn*(P_sh+1) edges after the start edge. DONEn is set and OUTn goes 0 on that edge; INTn rises one edge later.
- Read data is valid throughout the access phase. Reads have no side effects.
- Both channels are fully independent, but PERIOD is shared; each channel samples PERIOD only at start and at its own wraps.

## Test plan
- Reset: assert PRESET 2 cycles mid-burst -> OUT=2'b00, INT0=INT1=0, all registers read 0.
- Burst: PERIOD=3, DUTY0=1, BURST0=2, CTRL=0x5 -> OUT[0] pattern is 1,0,0,0,1,0,0,0, then 0. DONE0 is set 8 edges after the start; INT0 is 1 on the next edge; BUSY0 reads 0.
- W1C and collision: write STATUS=0x4 -> INT0 falls one edge later. Schedule the W1C on the same edge as a new DONE0 set -> DONE0 remains 1.
- Shadowing: channel 1 continuous, PERIOD=9, DUTY1=5. Write DUTY1=2 mid-period -> the current period still shows 5 high cycles, and the next period shows 2.
- Extremes: DUTY0=0 -> OUT[0] constant 0. DUTY0=PERIOD+1 -> constant 1. Both cases still report DONE at the correct edge.
- Abort: clear EN1 mid-period -> OUT[1]=0 on that edge, DONE1 stays 0, INT1 stays 0, and BUSY1 reads 0.
